// File: rtl/div_seq_pkg.sv
// Shared encodings for the multi-cycle divider sequencer.
package div_seq_pkg;

  // Divider FSM states; the encodings match the legacy 2-bit state constants.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic RST_ENABLE           = 1'b1;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU.
// Returns {remainder, quotient} DATA_W+1 edges after the request is sampled.
// A zero divisor short-cuts through BYZERO and returns zero after 2 edges.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W:0]       r_rem;   // partial remainder, one guard bit
  logic [DATA_W-1:0]     r_dvd;   // dividend shifts out the top, quotient shifts in the bottom
  logic [DATA_W-1:0]     r_dvs;   // magnitude of the divisor
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_req;
  logic                  w_neg1;
  logic                  w_neg2;
  logic [DATA_W-1:0]     w_abs1;
  logic [DATA_W-1:0]     w_abs2;
  logic [DATA_W:0]       w_shift_rem;
  logic [DATA_W+1:0]     w_trial;
  logic                  w_q_bit;
  logic [DATA_W:0]       w_rem_next;
  logic [DATA_W-1:0]     w_quo_next;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  // Operand magnitudes and sign flags for a request sampled in FREE.
  always_comb begin
    w_req  = (start_i == DIV_START) && !annul_i;
    w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
    w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
    w_abs1 = w_neg1 ? -opdata1_i : opdata1_i;
    w_abs2 = w_neg2 ? -opdata2_i : opdata2_i;
  end

  // One restoring step: shift, trial-subtract, keep or restore; sign-fix the final values.
  always_comb begin
    w_shift_rem = {r_rem[DATA_W-1:0], r_dvd[DATA_W-1]};
    w_trial     = {1'b0, w_shift_rem} - {2'b00, r_dvs};
    w_q_bit     = ~w_trial[DATA_W+1];
    w_rem_next  = w_q_bit ? w_trial[DATA_W:0] : w_shift_rem;
    w_quo_next  = {r_dvd[DATA_W-2:0], w_q_bit};
    w_quo_fix   = r_neg_q ? -w_quo_next : w_quo_next;
    w_rem_fix   = r_neg_r ? -w_rem_next[DATA_W-1:0] : w_rem_next[DATA_W-1:0];
  end

  // Sequencer FSM with registered result and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RESULT_NOT_READY;
          r_result <= '0;
          if (w_req) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state <= DIV_ON;
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_neg_q <= w_neg1 ^ w_neg2;
              r_neg_r <= w_neg1;
              r_cnt   <= '0;
              r_rem   <= '0;
            end
          end
        end
        DIV_BYZERO: begin
          r_state  <= DIV_END;
          r_result <= '0;
          r_ready  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          // A dropped request is treated as a kill, same as annul.
          if (annul_i || (start_i == DIV_STOP)) begin
            r_state <= DIV_FREE;
            r_ready <= DIV_RESULT_NOT_READY;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state  <= DIV_END;
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= DIV_RESULT_READY;
            end
          end
        end
        DIV_END: begin
          // Hold the result until ex releases the request; no restart from here.
          if ((start_i == DIV_STOP) || annul_i) begin
            r_state  <= DIV_FREE;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == DIV_ON) || (r_state == DIV_BYZERO);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a result scoreboard.
module tb_div_seq;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic            annul_i = 1'b0;
  logic            signed_div_i = 1'b0;
  logic [W-1:0]    opdata1_i = '0;
  logic [W-1:0]    opdata2_i = '0;
  logic [2*W-1:0]  result_o;
  logic            ready_o;
  logic            busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb[$];

  div_seq #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on the language's own division operators.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a; sb_ = b;
      sq = sa / sb_;
      sr = sa % sb_;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Issue one request, wait for ready, compare against the scoreboard, then release.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    int lat_exp;
    logic got;
    logic [63:0] exp;
    sb.push_back(model(sgn, a, b));
    lat_exp = (b == 32'd0) ? 2 : W + 1;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) check("busy_after_sample", {63'd0, busy_o}, 64'd1);
      if (ready_o) got = 1'b1;
    end
    check("latency", 64'(n), 64'(lat_exp));
    exp = sb.pop_front();
    if (got) begin
      check("result", result_o, exp);
      check("busy_in_end", {63'd0, busy_o}, 64'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_ready", {63'd0, ready_o}, 64'd1);
        check("hold_result", result_o, exp);
        check("hold_busy", {63'd0, busy_o}, 64'd0);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    check("release_ready", {63'd0, ready_o}, 64'd0);
    check("release_result", result_o, 64'd0);
    $display("div sgn=%0d a=%h b=%h result=%h latency=%0d", sgn, a, b, exp, n);
  endtask

  initial begin
    int ready_seen;
    // Reset state
    #12;
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Basic unsigned and signed cases
    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    // Divide by zero
    do_div(1'b0, 32'd5, 32'd0, 0);
    // Overflow and extremes
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div(1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 0);
    do_div(1'b1, 32'h8000_0001, 32'h0000_0003, 0);

    // Annul at iteration 10: back to FREE, no ready
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    $display("annul sgn=0 a=%h b=%h killed at step 10", 32'd1000, 32'd3);
    do_div(1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-division
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {63'd0, busy_o}, 64'd0);
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    $display("reset mid-division a=%h b=%h", 32'd12345, 32'd17);

    // Hold start through END: no restart, result stable
    do_div(1'b1, 32'hFFFF_FF00, 32'h0000_0007, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Multi-cycle divider sequencer beside the execute stage. It accepts a DIV/DIVU request from ex, runs a radix-2 restoring division over DATA_W cycles and returns {remainder, quotient} for the HI/LO write path. While it works, it holds busy_o high so the pipeline stall controller freezes ex.

Parameters:
DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  request level from ex; must stay high until ready_o is seen.
annul_i  in  1  cancels the request (flush or branch-likely kill).
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
opdata1_i  in  DATA_W  dividend; sampled with start_i.
opdata2_i  in  DATA_W  divisor; sampled with start_i.
result_o  out  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}.
ready_o  out  1  result valid.
busy_o  out  1  high in states ON and BYZERO.

Behaviour:
- Reset (async, rst=1): state=FREE, cnt=0, result_o=0, ready_o=0. Takes effect immediately, including mid-division.
- FSM states: FREE, BYZERO, ON, END. All outputs are registered or decoded from state only; there are no combinational paths from the inputs.
- FREE:
  - start_i=1 and annul_i=0, divisor==0: go to BYZERO.
  - start_i=1 and annul_i=0, divisor!=0: go to ON. Latch |dividend|, |divisor| (absolute values only when signed_div_i=1). Also latch the sign flags: neg_q = sign1 XOR sign2, neg_r = sign1. Clear cnt and the (DATA_W+1)-bit partial remainder.
  - Otherwise stay in FREE. ready_o=0, result_o=0.
- BYZERO: the next edge goes to END with result_o=0 and ready_o=1.
- ON, one restoring step per edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem - divisor. If trial is non-negative, rem = trial and the quotient bit is 1; otherwise rem is kept and the quotient bit is 0.
  - cnt increments.
  - On the edge where cnt == DATA_W-1 finishes its step, the state goes to END. On that same edge result_o is loaded with the sign-corrected values: quotient negated if neg_q, remainder negated if neg_r, both two's complement truncated to DATA_W. ready_o=1 from that edge.
  - annul_i=1 in ON: the next edge goes to FREE, ready_o stays 0 and result_o is unchanged.
  - start_i dropping in ON is treated the same as annul.
- END:
  - ready_o=1 and result_o is held.
  - start_i=0 or annul_i=1: go to FREE, clearing ready_o and result_o.
  - start_i stays 1: remain in END. There is no restart without first passing through FREE.
- Latency from the edge that samples start_i to ready_o going high:
  - nonzero divisor: DATA_W+1 edges (33 for W=32).
  - zero divisor: 2 edges.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is wrap behaviour and raises no exception.
- busy_o=1 exactly in ON and BYZERO. The ex stall request is busy_o OR (start_i AND state==FREE).

Decomposition:
- Add to defines.v:
  - state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady / DivResultNotReady, DivStart / DivStop.
  - DoubleRegBus [63:0].
- The existing RstEnable and ZeroWord constants are reused.
- No sub-module: the one-step subtract and shift stays inline; it is a single adder.

Test Plan:
1. DIVU 100/7: start_i held → ready_o rises 33 edges after the sampling edge, result_o={0x00000002, 0x0000000E}.
2. DIV -7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divide by zero, 5/0 → busy_o for 1 cycle, ready_o after 2 edges, result_o=0; then start_i=0 → FREE, ready_o=0 on the next edge.
4. Overflow, DIV 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
5. annul_i pulsed at iteration 10 → FREE next edge, ready_o never rises. A following DIVU 9/3 completes normally → {0, 3}.
6. rst asserted asynchronously mid-ON (between edges) → busy_o, ready_o and result_o are 0 immediately. start_i held through END for 5 extra cycles → result and ready_o stable, no restart.
